// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   rx_state_e : receiver FSM states
//   PAR_*      : encodings of the PARITY_MODE parameter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } rx_state_e;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_sampler.sv
// Input conditioning for the UART receiver: a 2-flop synchroniser on the
// asynchronous serial line plus two sample registers used for a 3-sample
// majority vote.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_async   : raw serial line (idle high)
//   strobe_a   : capture first sample (counter at MID-1)
//   strobe_b   : capture second sample (counter at MID)
//   rx_sync    : synchronised line
//   bit_maj    : majority of the two stored samples and the live third sample,
//                valid in the cycle the counter sits at MID+1
module uart_bit_sampler (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_async,
   input  logic strobe_a,
   input  logic strobe_b,
   output logic rx_sync,
   output logic bit_maj
);

   logic meta_q, sync_q, samp_a_q, samp_b_q;

   // Everything resets to the idle level so no false start is seen after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= 1'b1;
         sync_q   <= 1'b1;
         samp_a_q <= 1'b1;
         samp_b_q <= 1'b1;
      end else begin
         meta_q <= rx_async;
         sync_q <= meta_q;
         if (strobe_a) samp_a_q <= sync_q;
         if (strobe_b) samp_b_q <= sync_q;
      end
   end

   assign rx_sync = sync_q;
   assign bit_maj = (samp_a_q & samp_b_q) | (samp_a_q & sync_q) | (samp_b_q & sync_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/even/odd parity, 1 or 2
// stop bits) with synchroniser, 3-sample majority voting, start-bit glitch
// rejection and parity/framing/break reporting.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_RX_Serial    : asynchronous serial input, idle high
//   o_RX_DV        : one-cycle pulse when a frame completes
//   o_RX_Byte      : received data (LSB first on the line), held until next DV
//   o_Parity_Err   : parity mismatch on the last frame
//   o_Frame_Err    : a stop bit was sampled low on the last frame
//   o_Break        : last frame was a break (all zero incl. first stop bit)
//   o_Busy         : FSM not in IDLE
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   input  logic                 i_RX_Serial,
   output logic                 o_RX_DV,
   output logic [DATA_BITS-1:0] o_RX_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned MID = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_SA   = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_SB   = CW'(MID);
   localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);

   localparam logic [3:0] IDX_DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] IDX_STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic       HAS_PAR       = (PARITY_MODE != PAR_NONE);
   localparam logic       ODD_PAR       = (PARITY_MODE == PAR_ODD);

   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shadow_q, shadow_d, byte_q, byte_d;
   logic                 par_q, par_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic                 stop0_q, stop0_d;
   logic                 perr_q, perr_d, frerr_q, frerr_d, brk_q, brk_d, dv_q, dv_d;

   logic rx_sync, bit_maj, cnt_last, cnt_dec;
   logic frame_ferr, frame_stop0, frame_brk, frame_perr;

   uart_bit_sampler u_sampler (
      .clk      (i_Clk),
      .rst_n    (i_Rst_L),
      .rx_async (i_RX_Serial),
      .strobe_a (cnt_q == CNT_SA),
      .strobe_b (cnt_q == CNT_SB),
      .rx_sync  (rx_sync),
      .bit_maj  (bit_maj)
   );

   assign cnt_last = (cnt_q == CNT_LAST);
   assign cnt_dec  = (cnt_q == CNT_DEC);

   // Frame results including the stop-bit sample being decided this cycle.
   assign frame_ferr  = ferr_acc_q | ~bit_maj;
   assign frame_stop0 = (idx_q == 4'd0) ? ~bit_maj : stop0_q;
   assign frame_brk   = ~(|shadow_q) & ~par_q & frame_stop0;
   assign frame_perr  = HAS_PAR & (par_q ^ (^shadow_q) ^ ODD_PAR);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_last ? '0 : cnt_q + CW'(1);
      idx_d      = idx_q;
      shadow_d   = shadow_q;
      par_d      = par_q;
      ferr_acc_d = ferr_acc_q;
      stop0_d    = stop0_q;
      byte_d     = byte_q;
      perr_d     = perr_q;
      frerr_d    = frerr_q;
      brk_d      = brk_q;
      dv_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_sync) begin
               state_d    = START;
               // The entry edge counts as count 0 of the start bit.
               cnt_d      = CW'(1);
               par_d      = 1'b0;
               ferr_acc_d = 1'b0;
               stop0_d    = 1'b0;
            end
         end
         START: begin
            if (cnt_dec && bit_maj) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_last) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (cnt_dec) begin
               for (int i = 0; i < DATA_BITS; i++) begin
                  if (idx_q == 4'(i)) shadow_d[i] = bit_maj;
               end
            end
            if (cnt_last) begin
               if (idx_q == IDX_DATA_LAST) begin
                  idx_d   = '0;
                  state_d = HAS_PAR ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         PARITY: begin
            if (cnt_dec) par_d = bit_maj;
            if (cnt_last) state_d = STOP;
         end
         STOP: begin
            if (cnt_dec) begin
               ferr_acc_d = frame_ferr;
               stop0_d    = frame_stop0;
               if (idx_q == IDX_STOP_LAST) begin
                  // Finish mid-stop-bit so a following start bit is not missed.
                  byte_d  = shadow_q;
                  perr_d  = frame_perr;
                  frerr_d = frame_ferr;
                  brk_d   = frame_brk;
                  dv_d    = 1'b1;
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = frame_brk ? BREAK_WAIT : IDLE;
               end
            end else if (cnt_last) begin
               idx_d = idx_q + 4'd1;
            end
         end
         BREAK_WAIT: begin
            cnt_d = '0;
            if (rx_sync) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         par_q      <= 1'b0;
         ferr_acc_q <= 1'b0;
         stop0_q    <= 1'b0;
         byte_q     <= '0;
         perr_q     <= 1'b0;
         frerr_q    <= 1'b0;
         brk_q      <= 1'b0;
         dv_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         par_q      <= par_d;
         ferr_acc_q <= ferr_acc_d;
         stop0_q    <= stop0_d;
         byte_q     <= byte_d;
         perr_q     <= perr_d;
         frerr_q    <= frerr_d;
         brk_q      <= brk_d;
         dv_q       <= dv_d;
      end
   end

   assign o_RX_DV      = dv_q;
   assign o_RX_Byte    = byte_q;
   assign o_Parity_Err = perr_q;
   assign o_Frame_Err  = frerr_q;
   assign o_Break      = brk_q;
   assign o_Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg. Three instances: defaults (8N1, 217 clk/bit), even
// parity (16 clk/bit) and two stop bits (16 clk/bit). Expected frames are
// queued when driven and checked when the matching DV appears.
module tb_uart_rx_cfg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [2:0] rx_line;
   logic [2:0] dv, perr, ferr, brk, busy;
   logic [7:0] rbyte [3];

   int edge_cnt = 0;
   int n_checks = 0;
   int n_pass   = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   uart_rx_cfg u_def (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_line[0]),
      .o_RX_DV(dv[0]), .o_RX_Byte(rbyte[0]), .o_Parity_Err(perr[0]),
      .o_Frame_Err(ferr[0]), .o_Break(brk[0]), .o_Busy(busy[0])
   );

   uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_par (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_line[1]),
      .o_RX_DV(dv[1]), .o_RX_Byte(rbyte[1]), .o_Parity_Err(perr[1]),
      .o_Frame_Err(ferr[1]), .o_Break(brk[1]), .o_Busy(busy[1])
   );

   uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_two (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_line[2]),
      .o_RX_DV(dv[2]), .o_RX_Byte(rbyte[2]), .o_Parity_Err(perr[2]),
      .o_Frame_Err(ferr[2]), .o_Break(brk[2]), .o_Busy(busy[2])
   );

   typedef struct {
      logic [7:0] byte_v;
      logic       perr;
      logic       ferr;
      logic       brk;
      int         dv_edge;
   } exp_t;

   typedef struct {
      int         d;
      logic [7:0] data;
      int         par;    // -1: no parity bit sent
      logic [1:0] stops;  // stop bit i sent as stops[i]
      logic       b2b;    // no idle gap before this frame
      logic [7:0] eb;
      logic       pe;
      logic       fe;
      logic       br;
   } vec_t;

   exp_t q0[$], q1[$], q2[$];

   function automatic int cpb(input int d);
      return (d == 0) ? 217 : 16;
   endfunction

   function automatic int nstop(input int d);
      return (d == 2) ? 2 : 1;
   endfunction

   function automatic int mid(input int d);
      return (cpb(d) - 1) / 2;
   endfunction

   function automatic int lat(input int d);
      int f;
      f = 1 + 8 + ((d == 1) ? 1 : 0) + nstop(d);
      return 3 + (f - 1) * cpb(d) + mid(d);
   endfunction

   function automatic int qsize(input int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qpush(input int d, input exp_t e);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic qpop(input int d, output exp_t e);
      case (d)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_dv(input int d);
      exp_t e;
      int   sz;
      sz = qsize(d);
      chk($sformatf("dut%0d_dv_expected", d), (sz > 0) ? 1 : 0, 1);
      if (sz > 0) begin
         qpop(d, e);
         chk($sformatf("dut%0d_byte", d), int'(rbyte[d]), int'(e.byte_v));
         chk($sformatf("dut%0d_parity_err", d), int'(perr[d]), int'(e.perr));
         chk($sformatf("dut%0d_frame_err", d), int'(ferr[d]), int'(e.ferr));
         chk($sformatf("dut%0d_break", d), int'(brk[d]), int'(e.brk));
         chk($sformatf("dut%0d_dv_edge", d), edge_cnt, e.dv_edge);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (dv[d] === 1'b1) check_dv(d);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after a posedge; the next posedge is edge 0.
   task automatic push_exp(input int d, input logic [7:0] b, input logic pe, fe, br);
      exp_t e;
      e.byte_v  = b;
      e.perr    = pe;
      e.ferr    = fe;
      e.brk     = br;
      e.dv_edge = edge_cnt + 1 + lat(d);
      qpush(d, e);
   endtask

   task automatic drive_bit(input int d, input logic v, input logic glitch);
      rx_line[d] = v;
      if (glitch) begin
         repeat (mid(d)) @(posedge clk);
         #1 rx_line[d] = ~v;
         @(posedge clk);
         #1 rx_line[d] = v;
         repeat (cpb(d) - mid(d) - 1) @(posedge clk);
         #1;
      end else begin
         repeat (cpb(d)) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int d, input logic [7:0] data, input int par,
                             input logic [1:0] stops, input int glitch_bit,
                             input logic [7:0] eb, input logic pe, fe, br);
      push_exp(d, eb, pe, fe, br);
      drive_bit(d, 1'b0, glitch_bit == 0);
      for (int i = 0; i < 8; i++) drive_bit(d, data[i], glitch_bit == i + 1);
      if (par >= 0) drive_bit(d, (par == 1), 1'b0);
      for (int i = 0; i < nstop(d); i++) drive_bit(d, stops[i], 1'b0);
      rx_line[d] = 1'b1;
   endtask

   task automatic drain(input int d, input int budget);
      int k;
      k = 0;
      while (qsize(d) > 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk($sformatf("dut%0d_scoreboard_drained", d), qsize(d), 0);
   endtask

   task automatic wait_edge(input int target);
      while (edge_cnt < target) @(negedge clk);
   endtask

   vec_t vt[11];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      vt[0]  = '{0, 8'hA5, -1, 2'b11, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{0, 8'h55, -1, 2'b10, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
      vt[2]  = '{1, 8'h37,  0, 2'b11, 1'b0, 8'h37, 1'b1, 1'b0, 1'b0};
      vt[3]  = '{1, 8'h37,  1, 2'b11, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{1, 8'h00,  0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{1, 8'h01,  0, 2'b00, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
      vt[6]  = '{1, 8'h00,  0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      vt[7]  = '{2, 8'h11, -1, 2'b11, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{2, 8'h22, -1, 2'b11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{2, 8'hC3, -1, 2'b01, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};
      vt[10] = '{2, 8'h00, -1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

      // Reset state
      rst_n   = 1'b0;
      rx_line = 3'b111;
      idle(5);
      chk("reset_dv", int'(dv[0]), 0);
      chk("reset_byte", int'(rbyte[0]), 0);
      chk("reset_parity_err", int'(perr[0]), 0);
      chk("reset_frame_err", int'(ferr[0]), 0);
      chk("reset_break", int'(brk[0]), 0);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      idle(5);

      // Table-driven frames
      for (int i = 0; i < 11; i++) begin
         if (!vt[i].b2b) idle(2 * cpb(vt[i].d));
         send_frame(vt[i].d, vt[i].data, vt[i].par, vt[i].stops, -1,
                    vt[i].eb, vt[i].pe, vt[i].fe, vt[i].br);
         if (i == 10 || !vt[i + 1].b2b) begin
            drain(vt[i].d, 4 * cpb(vt[i].d));
            idle(2 * cpb(vt[i].d));
            chk($sformatf("vec%0d_busy_after", i), int'(busy[vt[i].d]), 0);
         end
      end

      // Start-bit glitch of 50 cycles: rejected at edge 2 + MID + 1
      n = edge_cnt;
      rx_line[0] = 1'b0;
      repeat (50) @(posedge clk);
      #1 rx_line[0] = 1'b1;
      wait_edge(n + 1 + 2 + mid(0));
      chk("glitch_busy_before_reject", int'(busy[0]), 1);
      wait_edge(n + 1 + 2 + mid(0) + 1);
      chk("glitch_busy_after_reject", int'(busy[0]), 0);
      idle(2 * cpb(0));

      // Break: line low for 12 bit-times, then a clean frame
      push_exp(0, 8'h00, 1'b0, 1'b1, 1'b1);
      rx_line[0] = 1'b0;
      repeat (12 * cpb(0)) @(posedge clk);
      #1;
      chk("break_dv_seen", qsize(0), 0);
      chk("break_wait_busy", int'(busy[0]), 1);
      rx_line[0] = 1'b1;
      idle(10);
      chk("break_released_busy", int'(busy[0]), 0);
      idle(cpb(0));
      send_frame(0, 8'h3C, -1, 2'b11, -1, 8'h3C, 1'b0, 1'b0, 1'b0);
      drain(0, 4 * cpb(0));
      idle(2 * cpb(0));

      // One-cycle inversion at MID of data bit 3
      send_frame(0, 8'h5A, -1, 2'b11, 4, 8'h5A, 1'b0, 1'b0, 1'b0);
      drain(0, 4 * cpb(0));
      idle(2 * cpb(0));

      // Reset during bit 4 of 0xFF: aborted, no DV
      drive_bit(0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_dv", int'(dv[0]), 0);
      chk("midreset_byte", int'(rbyte[0]), 0);
      chk("midreset_parity_err", int'(perr[0]), 0);
      chk("midreset_frame_err", int'(ferr[0]), 0);
      chk("midreset_break", int'(brk[0]), 0);
      chk("midreset_busy", int'(busy[0]), 0);
      idle(20);
      rst_n = 1'b1;
      idle(cpb(0));
      send_frame(0, 8'h81, -1, 2'b11, -1, 8'h81, 1'b0, 1'b0, 1'b0);
      drain(0, 4 * cpb(0));
      idle(2 * cpb(0));
      chk("final_busy", int'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
